sprite_frame_streamer: RTL

//  Consumer end of the game-logic position bus. On each frame_start pulse it snapshots all five

---
 rtl/sprite_frame_streamer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sprite_frame_streamer.sv
// Snapshots the five sprite positions on frame_start and streams them as valid/ready records.
// Also tracks lives: a captured death decrements lives and requests a game-logic respawn.
module sprite_frame_streamer #(
  parameter int NUM_LIVES      = 3,
  parameter int LIVES_W        = 2,
  parameter int RESPAWN_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [10:0]        pacman_pos_x,
  input  logic [9:0]         pacman_pos_y,
  input  logic [10:0]        blinky_pos_x,
  input  logic [9:0]         blinky_pos_y,
  input  logic [10:0]        pinky_pos_x,
  input  logic [9:0]         pinky_pos_y,
  input  logic [10:0]        inky_pos_x,
  input  logic [9:0]         inky_pos_y,
  input  logic [10:0]        clyde_pos_x,
  input  logic [9:0]         clyde_pos_y,
  input  logic [3:0]         pacman_dir,
  input  logic               pacman_is_dead,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [2:0]         rec_id,
  output logic [10:0]        rec_x,
  output logic [9:0]         rec_y,
  output logic [3:0]         rec_dir,
  output logic               rec_last,
  output logic               busy,
  output logic [LIVES_W-1:0] lives_left,
  output logic               respawn_req,
  output logic               game_over,
  output logic               frame_overrun
);

  localparam int CNT_W = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [2:0] LAST_ID = 3'd4;

  typedef enum logic [1:0] {IDLE, SEND, RESPAWN} state_e;

  state_e              state_q, state_d;
  logic [2:0]          id_q, id_d;
  logic [4:0][10:0]    x_snap_q, x_snap_d;
  logic [4:0][9:0]     y_snap_q, y_snap_d;
  logic [3:0]          dir_snap_q, dir_snap_d;
  logic                dead_snap_q, dead_snap_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                game_over_q, game_over_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= '0;
      x_snap_q    <= '0;
      y_snap_q    <= '0;
      dir_snap_q  <= '0;
      dead_snap_q <= 1'b0;
      lives_q     <= LIVES_W'(NUM_LIVES);
      game_over_q <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      x_snap_q    <= x_snap_d;
      y_snap_q    <= y_snap_d;
      dir_snap_q  <= dir_snap_d;
      dead_snap_q <= dead_snap_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    x_snap_d    = x_snap_q;
    y_snap_d    = y_snap_q;
    dir_snap_d  = dir_snap_q;
    dead_snap_d = dead_snap_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    overrun_d   = overrun_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          x_snap_d    = {clyde_pos_x, inky_pos_x, pinky_pos_x, blinky_pos_x, pacman_pos_x};
          y_snap_d    = {clyde_pos_y, inky_pos_y, pinky_pos_y, blinky_pos_y, pacman_pos_y};
          dir_snap_d  = pacman_dir;
          dead_snap_d = pacman_is_dead;
          id_d        = '0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (frame_start) overrun_d = 1'b1;
        if (rec_ready) begin
          if (id_q == LAST_ID) begin
            state_d = IDLE;
            // Death accounting happens on the final handshake; game over freezes lives.
            if (dead_snap_q && !game_over_q) begin
              if (lives_q > LIVES_W'(1)) begin
                lives_d = lives_q - LIVES_W'(1);
                cnt_d   = CNT_W'(RESPAWN_CYCLES - 1);
                state_d = RESPAWN;
              end else begin
                lives_d     = '0;
                game_over_d = 1'b1;
              end
            end
          end else begin
            id_d = id_q + 3'd1;
          end
        end
      end
      RESPAWN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Record fields are forced to zero whenever no record is presented.
  assign rec_valid     = (state_q == SEND);
  assign rec_id        = rec_valid ? id_q : 3'd0;
  assign rec_x         = rec_valid ? x_snap_q[id_q] : 11'd0;
  assign rec_y         = rec_valid ? y_snap_q[id_q] : 10'd0;
  assign rec_dir       = (rec_valid && id_q == 3'd0) ? dir_snap_q : 4'd0;
  assign rec_last      = rec_valid && (id_q == LAST_ID);
  assign busy          = (state_q != IDLE);
  assign respawn_req   = (state_q == RESPAWN);
  assign lives_left    = lives_q;
  assign game_over     = game_over_q;
  assign frame_overrun = overrun_q;

endmodule
